// File: rtl/lru_matrix_pipe.sv
// Pipelined matrix-LRU tracker: one NUM_WAYS x NUM_WAYS age matrix per cache index,
// self-initialised after reset, one query/touch/invalidate per cycle with 1-cycle response.
module lru_matrix_pipe #(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = $clog2(NUM_WAYS),
  parameter int NUM_SETS = 64,
  parameter int INDEX_W  = $clog2(NUM_SETS)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [1:0]         req_op_i,
  input  logic [INDEX_W-1:0] req_index_i,
  input  logic [WAY_W-1:0]   req_way_i,
  output logic               rsp_valid_o,
  output logic [WAY_W-1:0]   rsp_victim_o,
  output logic               init_done_o
);

  localparam logic [1:0] OP_TOUCH = 2'b01;
  localparam logic [1:0] OP_INV   = 2'b10;

  typedef logic [NUM_WAYS-1:0][NUM_WAYS-1:0] mat_t;
  typedef struct packed {
    logic [1:0]         op;
    logic [INDEX_W-1:0] idx;
    logic [WAY_W-1:0]   way;
  } req_t;
  typedef enum logic {INIT, RUN} state_e;

  state_e             state;
  logic [INDEX_W-1:0] sweep;
  mat_t               mem [NUM_SETS];
  mat_t               canon, rd_mat, upd_mat, s1_mat;
  req_t               s1_req;
  logic               s1_vld;
  logic               accept, fwd;

  // Lowest-numbered way with an all-zero row; way 0 if the matrix is corrupt.
  function automatic logic [WAY_W-1:0] victim_of(input mat_t m);
    logic [WAY_W-1:0] v;
    v = '0;
    for (int i = NUM_WAYS-1; i >= 0; i--)
      if (m[i] == '0) v = WAY_W'(i);
    return v;
  endfunction

  always_comb begin
    canon = '0;
    for (int i = 0; i < NUM_WAYS; i++)
      for (int j = 0; j < NUM_WAYS; j++)
        if (j < i) canon[i][j] = 1'b1;
  end

  always_comb begin
    upd_mat = s1_mat;
    for (int i = 0; i < NUM_WAYS; i++)
      for (int j = 0; j < NUM_WAYS; j++)
        if (i != j) begin
          if (s1_req.op == OP_TOUCH) begin
            if (i == int'(s1_req.way))      upd_mat[i][j] = 1'b1;
            else if (j == int'(s1_req.way)) upd_mat[i][j] = 1'b0;
          end else if (s1_req.op == OP_INV) begin
            if (i == int'(s1_req.way))      upd_mat[i][j] = 1'b0;
            else if (j == int'(s1_req.way)) upd_mat[i][j] = 1'b1;
          end
        end
  end

  assign accept = req_valid_i && req_ready_o;
  // Same-index back-to-back ops must see the not-yet-written stage-1 result.
  assign fwd    = s1_vld && (s1_req.idx == req_index_i);

  always_comb begin
    rd_mat = fwd ? upd_mat : mem[req_index_i];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= INIT;
      sweep        <= '0;
      req_ready_o  <= 1'b0;
      init_done_o  <= 1'b0;
      s1_vld       <= 1'b0;
      s1_req       <= '0;
      s1_mat       <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_victim_o <= '0;
    end else begin
      s1_vld      <= accept;
      rsp_valid_o <= accept;
      if (accept) begin
        s1_req       <= '{op: req_op_i, idx: req_index_i, way: req_way_i};
        s1_mat       <= rd_mat;
        rsp_victim_o <= victim_of(rd_mat);
      end
      case (state)
        INIT: begin
          sweep <= sweep + 1'b1;
          if (sweep == INDEX_W'(NUM_SETS-1)) begin
            state       <= RUN;
            req_ready_o <= 1'b1;
            init_done_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Reset drops any in-flight write-back; the sweep rewrites every index anyway.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (state == INIT)
        mem[sweep] <= canon;
      else if (s1_vld && (s1_req.op == OP_TOUCH || s1_req.op == OP_INV))
        mem[s1_req.idx] <= upd_mat;
    end
  end

endmodule

// File: tb/tb_lru_matrix_pipe.sv
// Bench for lru_matrix_pipe: per-index age-rank reference model, per-cycle compare,
// directed sequences pinned by literal victim lists, then randomized traffic.
module tb_lru_matrix_pipe;
  localparam int NW = 4;
  localparam int WW = $clog2(NW);
  localparam int NS = 64;
  localparam int IW = $clog2(NS);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic [IW-1:0] req_index = '0;
  logic [WW-1:0] req_way = '0;
  logic          rsp_valid;
  logic [WW-1:0] rsp_victim;
  logic          init_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lru_matrix_pipe #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_index_i(req_index), .req_way_i(req_way),
    .rsp_valid_o(rsp_valid), .rsp_victim_o(rsp_victim), .init_done_o(init_done)
  );

  // Model: rank[s][w] is way w's age position, 0 = LRU .. NW-1 = MRU.
  int rank [NS][NW];
  int cnt = 0;
  bit chk_en = 0;
  bit pend = 0;
  logic [WW-1:0] hold = '0;
  int rsp_log[$];
  int exp_q[$];

  function automatic void model_init();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) rank[s][w] = w;
  endfunction

  function automatic int model_victim(input int s);
    for (int w = 0; w < NW; w++) if (rank[s][w] == 0) return w;
    return 0;
  endfunction

  function automatic void model_apply(input int op, input int s, input int w);
    int r;
    r = rank[s][w];
    if (op == 1) begin
      for (int v = 0; v < NW; v++) if (rank[s][v] > r) rank[s][v]--;
      rank[s][w] = NW-1;
    end else if (op == 2) begin
      for (int v = 0; v < NW; v++) if (rank[s][v] < r) rank[s][v]++;
      rank[s][w] = 0;
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (req_ready !== (cnt >= NS) || init_done !== (cnt >= NS)) begin
        errors++;
        $display("FAIL ready: ready=%b init_done=%b want %b", req_ready, init_done, cnt >= NS);
      end
      checks++;
      if (rsp_valid !== pend) begin
        errors++;
        $display("FAIL rsp_valid: got %b want %b", rsp_valid, pend);
      end
      checks++;
      if (rsp_victim !== hold) begin
        errors++;
        $display("FAIL victim: got %0d want %0d (valid=%b)", rsp_victim, hold, rsp_valid);
      end
      if (rsp_valid === 1'b1) rsp_log.push_back(int'(rsp_victim));
    end
    // Plan for the coming edge from the inputs it will sample.
    if (!rst_n) begin
      chk_en = 1; cnt = 0; pend = 0; hold = '0;
      model_init();
    end else begin
      pend = req_valid && (cnt >= NS);
      if (pend) begin
        hold = WW'(model_victim(int'(req_index)));
        model_apply((req_op == 2'b11) ? 0 : int'(req_op), int'(req_index), int'(req_way));
      end
      if (cnt < NS) cnt++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input int op, input int idx, input int way);
    req_valid = 1'b1; req_op = 2'(op); req_index = IW'(idx); req_way = WW'(way);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin step(); n++; end
    checks++;
    if (n != NS) begin
      errors++;
      $display("FAIL %s: ready after %0d cycles, want %0d", nm, n, NS);
    end
  endtask

  task automatic check_log(input string nm);
    step(); step();
    checks++;
    if (rsp_log != exp_q) begin
      errors++;
      $display("FAIL %s: got %p want %p", nm, rsp_log, exp_q);
    end
    rsp_log.delete();
  endtask

  initial begin
    model_init();
    step(); step();
    rst_n = 1'b1;
    wait_ready("init_latency");

    rsp_log.delete();
    issue(0, 17, 0);
    exp_q = '{0};
    check_log("query_after_init");

    issue(1, 5, 0); issue(1, 5, 1); issue(1, 5, 2); issue(0, 5, 0);
    exp_q = '{0, 1, 2, 3};
    check_log("fwd_idx5");

    issue(1, 3, 3); issue(1, 3, 2); issue(1, 3, 1); issue(1, 3, 0);
    issue(2, 3, 2); issue(0, 3, 0); issue(1, 3, 2); issue(0, 3, 0);
    exp_q = '{0, 0, 0, 0, 3, 2, 2, 3};
    check_log("inv_idx3");

    issue(1, 7, 0); issue(1, 8, 1); issue(0, 7, 0); issue(0, 8, 0);
    exp_q = '{0, 0, 1, 0};
    check_log("indep_7_8");

    // In-flight invalidate dropped by reset, then reset again mid-sweep.
    issue(2, 40, 3);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    repeat (30) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    wait_ready("midsweep_reset");
    rsp_log.delete();
    issue(0, 40, 0);
    exp_q = '{0};
    check_log("idx40_after_reset");

    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 2999) == 0) begin
        req_valid = 1'b0;
        rst_n = 1'b0; step(); rst_n = 1'b1;
      end else begin
        req_valid = ($urandom % 4) != 0;
        req_op    = 2'($urandom);
        req_index = ($urandom % 2 != 0) ? IW'($urandom % 4) : IW'($urandom);
        req_way   = WW'($urandom);
        step();
      end
    end
    req_valid = 1'b0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
